// File: rtl/shifter_seq.sv
// Sequential barrel shifter: one log2 stage per cycle, LSB stage first.
// Fixed latency; results and error flag are registered and held.
module shifter_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(SHW + 1);

  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_ROR = 6'b000100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [5:0]       op;
  logic [WIDTH-1:0] amt;
  logic             msb;
  logic [WIDTH-1:0] w;
  logic [CW-1:0]    cnt;

  logic [SHW-1:0]     sh;
  logic               take;
  logic [2*WIDTH-1:0] dd;
  logic [WIDTH-1:0]   stepped;
  logic               valid;
  logic               big;
  logic [WIDTH-1:0]   result;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(SHW - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage k shifts by 2^k when amount bit k is set.
  always_comb begin
    sh   = SHW'(1) << cnt;
    take = |(amt[SHW-1:0] & sh);
    dd   = {w, w} >> sh;
    case (op)
      OP_SLL:  stepped = w << sh;
      OP_SRL:  stepped = w >> sh;
      OP_SRA:  stepped = $signed(w) >>> sh;
      OP_ROR:  stepped = dd[WIDTH-1:0];
      default: stepped = w;
    endcase
  end

  // Amounts >= WIDTH saturate, except rotate which wraps.
  always_comb begin
    valid  = (op == OP_SLL) || (op == OP_SRL) ||
             (op == OP_SRA) || (op == OP_ROR);
    big    = |amt[WIDTH-1:SHW];
    result = w;
    if (!valid)
      result = '0;
    else if (big && (op == OP_SLL || op == OP_SRL))
      result = '0;
    else if (big && op == OP_SRA)
      result = {WIDTH{msb}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op      <= '0;
      amt     <= '0;
      msb     <= 1'b0;
      w       <= '0;
      cnt     <= '0;
      dataOut <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op  <= Signal;
            amt <= dataB;
            msb <= dataA[WIDTH-1];
            w   <= dataA;
            cnt <= '0;
          end
        end
        SHIFT: begin
          if (take) w <= stepped;
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          dataOut <= result;
          err     <= !valid;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
